vote_session: RTL and testbench

//  Parametrised, sequential successor to the single-shot combinational vote block.

---
 rtl/vote_session.sv | 143 ++++++++++++++
 tb/tb_vote_session.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session.sv
// Sequential weighted-vote collector: gathers ROUNDS ballot beats per session
// over valid/ready, then issues a registered verdict under the latched rule.
module vote_session #(
  parameter int unsigned NP_W    = 32,
  parameter int unsigned VIP_W   = 8,
  parameter int unsigned VIP_WT  = 4,
  parameter int unsigned VVIP_WT = 16,
  parameter int unsigned ROUNDS  = 4,
  localparam int unsigned MAXW   = NP_W + VIP_W * VIP_WT + VVIP_WT,
  localparam int unsigned TOTAL  = ROUNDS * MAXW,
  localparam int unsigned CW     = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             veto_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NP_W-1:0]  np,
  input  logic [VIP_W-1:0] vip,
  input  logic             vvip,
  output logic             busy,
  output logic             done,
  output logic             res,
  output logic [CW-1:0]    yes_cnt
);

  localparam int unsigned BW = (ROUNDS > 1) ? $clog2(ROUNDS + 1) : 1;
  localparam logic [CW+1:0] TOT_X = (CW+2)'(TOTAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_TALLY,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic          veto_en_q, veto_en_d;
  logic          veto_q, veto_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          res_q, res_d;
  logic [CW-1:0] yes_cnt_q, yes_cnt_d;

  logic [CW-1:0] beat_w;
  logic [CW+1:0] acc_x;
  logic          rule_ok;
  logic          accept;

  // Weighted yes contribution of the beat currently on the inputs.
  always_comb begin
    beat_w = '0;
    for (int unsigned i = 0; i < NP_W; i++) begin
      beat_w = beat_w + CW'(np[i]);
    end
    for (int unsigned i = 0; i < VIP_W; i++) begin
      if (vip[i]) beat_w = beat_w + CW'(VIP_WT);
    end
    if (vvip) beat_w = beat_w + CW'(VVIP_WT);
  end

  always_comb begin
    acc_x = {2'b00, acc_q};
    case (mode_q)
      2'b01:   rule_ok = (acc_x + (acc_x << 1)) >= (TOT_X << 1);
      2'b10:   rule_ok = (acc_x == TOT_X);
      default: rule_ok = (acc_x << 1) > TOT_X;
    endcase
  end

  assign accept = in_valid && (state_q == S_COLLECT);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    veto_en_d = veto_en_q;
    veto_d    = veto_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    res_d     = res_q;
    yes_cnt_d = yes_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COLLECT;
          mode_d    = mode;
          veto_en_d = veto_en;
          veto_d    = 1'b0;
          acc_d     = '0;
          beat_d    = '0;
          res_d     = 1'b0;
          yes_cnt_d = '0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          acc_d  = acc_q + beat_w;
          beat_d = beat_q + 1'b1;
          if (veto_en_q && !vvip) veto_d = 1'b1;
          if (beat_q == BW'(ROUNDS - 1)) state_d = S_TALLY;
        end
      end
      S_TALLY: begin
        yes_cnt_d = acc_q;
        res_d     = rule_ok && !veto_q;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      veto_en_q <= 1'b0;
      veto_q    <= 1'b0;
      acc_q     <= '0;
      beat_q    <= '0;
      res_q     <= 1'b0;
      yes_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      veto_en_q <= veto_en_d;
      veto_q    <= veto_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      res_q     <= res_d;
      yes_cnt_q <= yes_cnt_d;
    end
  end

  assign in_ready = (state_q == S_COLLECT);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign res      = res_q;
  assign yes_cnt  = yes_cnt_q;

endmodule

// File: tb/tb_vote_session.sv
// Scoreboard bench for vote_session: expected verdicts are queued as sessions
// are driven and popped when the DUT pulses done.
module tb_vote_session;
  localparam int NP_W = 32, VIP_W = 8, VIP_WT = 4, VVIP_WT = 16, ROUNDS = 4;
  localparam int TOTAL = ROUNDS * (NP_W + VIP_W * VIP_WT + VVIP_WT);
  localparam int CW = 9;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             veto_en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NP_W-1:0]  np = '0;
  logic [VIP_W-1:0] vip = '0;
  logic             vvip = 1'b0;
  logic             busy, done, res;
  logic [CW-1:0]    yes_cnt;

  vote_session #(.NP_W(NP_W), .VIP_W(VIP_W), .VIP_WT(VIP_WT), .VVIP_WT(VVIP_WT),
                 .ROUNDS(ROUNDS)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .veto_en(veto_en),
    .in_valid(in_valid), .in_ready(in_ready), .np(np), .vip(vip), .vvip(vvip),
    .busy(busy), .done(done), .res(res), .yes_cnt(yes_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int yes; bit res; } exp_t;
  exp_t sb[$];

  logic [NP_W-1:0]  np_a[ROUNDS];
  logic [VIP_W-1:0] vip_a[ROUNDS];
  logic             vvip_a[ROUNDS];

  int passed = 0;
  int total  = 0;

  function automatic exp_t model(input logic [1:0] m, input bit ve);
    exp_t e;
    int s = 0;
    bit vt = 0;
    for (int b = 0; b < ROUNDS; b++) begin
      s += $countones(np_a[b]) + VIP_WT * $countones(vip_a[b]) + VVIP_WT * int'(vvip_a[b]);
      if (ve && !vvip_a[b]) vt = 1;
    end
    case (m)
      2'b01:   e.res = (3 * s >= 2 * TOTAL);
      2'b10:   e.res = (s == TOTAL);
      default: e.res = (2 * s > TOTAL);
    endcase
    e.res = e.res && !vt;
    e.yes = s;
    return e;
  endfunction

  task automatic set_beats(input logic [NP_W-1:0] n, input logic [VIP_W-1:0] v, input logic vv);
    for (int b = 0; b < ROUNDS; b++) begin
      np_a[b] = n; vip_a[b] = v; vvip_a[b] = vv;
    end
  endtask

  // Drives one session; accepts `beats` beats, pulses start at cycle `sp_at` of COLLECT.
  task automatic drive_session(input logic [1:0] m, input bit ve, input bit bubbles,
                               input int sp_at, input int beats);
    int n = 0;
    int cyc = 0;
    bit acc;
    @(posedge clk); #1;
    start = 1'b1; mode = m; veto_en = ve;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); veto_en = 1'($urandom);
    if (beats == ROUNDS) sb.push_back(model(m, ve));
    while (n < beats && cyc < 200) begin
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid) begin
        np = np_a[n]; vip = vip_a[n]; vvip = vvip_a[n];
      end else begin
        np = $urandom; vip = 8'($urandom); vvip = 1'($urandom);
      end
      start = (cyc == sp_at);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      cyc++;
    end
    start = 1'b0;
    total++;
    if (n !== beats) $display("FAIL beats_accepted: got %0d want %0d", n, beats);
    else passed++;
    // Keep offering ones-beats past the last accept to catch an extra take.
    if (bubbles) begin
      in_valid = 1'b1; np = '1; vip = '1; vvip = 1'b1;
    end else in_valid = 1'b0;
  endtask

  task automatic collect_result(output bit got, output int lat, output int y, output bit r,
                                output exp_t e, output bit single);
    got = 0; lat = 0;
    while (!got && lat < 10) begin
      if (done === 1'b1) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    y = int'(yes_cnt); r = res;
    @(posedge clk); #1;
    single = (done === 1'b0);
    in_valid = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.yes = -1; e.res = 0; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, res, in_ready, yes_cnt} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b res=%b in_ready=%b yes_cnt=%0d want all 0",
               busy, done, res, in_ready, yes_cnt);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_t1;
    bit got, r, single; int lat, y; exp_t e;
    set_beats('1, 8'hA9, 1'b1);
    drive_session(2'b00, 1'b0, 1'b0, -1, ROUNDS);
    total++;
    if (busy !== 1'b1) $display("FAIL t1_busy_tally: got %b want 1", busy); else passed++;
    collect_result(got, lat, y, r, e, single);
    total++;
    if (!got || lat != 1) $display("FAIL t1_latency: got=%0d lat=%0d want 1", got, lat); else passed++;
    total++;
    if (y != e.yes || y != 256) $display("FAIL t1_yes_cnt: got %0d want %0d", y, e.yes); else passed++;
    total++;
    if (r !== e.res) $display("FAIL t1_res: got %b want %b", r, e.res); else passed++;
    total++;
    if (!single) $display("FAIL t1_done_pulse: done still %b want 0", done); else passed++;
    total++;
    if (int'(yes_cnt) != e.yes || res !== e.res || busy !== 1'b0)
      $display("FAIL t1_hold: yes_cnt=%0d res=%b busy=%b want %0d %b 0", yes_cnt, res, busy, e.yes, e.res);
    else passed++;
  endtask

  task automatic test_t2;
    bit got, r, single; int lat, y; exp_t e;
    set_beats('0, 8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive_session(k == 0 ? 2'b01 : 2'b00, 1'b0, 1'b0, -1, ROUNDS);
      collect_result(got, lat, y, r, e, single);
      total++;
      if (!got || y != e.yes) $display("FAIL t2_yes_cnt_%0d: got %0d want %0d", k, y, e.yes); else passed++;
      total++;
      if (r !== e.res) $display("FAIL t2_res_%0d: got %b want %b", k, r, e.res); else passed++;
    end
  endtask

  task automatic test_veto;
    bit got, r, single; int lat, y; exp_t e;
    set_beats('1, '1, 1'b1);
    vvip_a[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_session(2'b00, k == 0, 1'b0, -1, ROUNDS);
      collect_result(got, lat, y, r, e, single);
      total++;
      if (!got || y != e.yes) $display("FAIL t3_yes_cnt_%0d: got %0d want %0d", k, y, e.yes); else passed++;
      total++;
      if (r !== e.res) $display("FAIL t3_res_veto%0d: got %b want %b", 1 - k, r, e.res); else passed++;
    end
  endtask

  task automatic test_unanimous;
    bit got, r, single; int lat, y; exp_t e;
    for (int k = 0; k < 2; k++) begin
      set_beats('1, '1, 1'b1);
      if (k == 1) np_a[2][5] = 1'b0;
      drive_session(2'b10, 1'b0, 1'b0, -1, ROUNDS);
      collect_result(got, lat, y, r, e, single);
      total++;
      if (!got || y != e.yes) $display("FAIL t4_yes_cnt_%0d: got %0d want %0d", k, y, e.yes); else passed++;
      total++;
      if (r !== e.res) $display("FAIL t4_res_%0d: got %b want %b", k, r, e.res); else passed++;
    end
  endtask

  task automatic test_bubbles;
    bit got, r, single; int lat, y; exp_t e;
    set_beats('1, 8'hA9, 1'b1);
    in_valid = 1'b1; np = '1; vip = '1; vvip = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL t5_idle_ready: in_ready=%b busy=%b want 0 0", in_ready, busy);
    else passed++;
    drive_session(2'b00, 1'b0, 1'b1, 2, ROUNDS);
    total++;
    if (in_ready !== 1'b0) $display("FAIL t5_ready_drop: got %b want 0", in_ready); else passed++;
    collect_result(got, lat, y, r, e, single);
    total++;
    if (!got || lat != 1) $display("FAIL t5_latency: got=%0d lat=%0d want 1", got, lat); else passed++;
    total++;
    if (y != e.yes || r !== e.res)
      $display("FAIL t5_result: yes_cnt=%0d res=%b want %0d %b", y, r, e.yes, e.res);
    else passed++;
    total++;
    if (!single) $display("FAIL t5_done_pulse: done=%b want 0", done); else passed++;
  endtask

  task automatic test_reset_mid;
    bit got, r, single; int lat, y; exp_t e;
    set_beats('1, 8'hA9, 1'b1);
    drive_session(2'b00, 1'b0, 1'b0, -1, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({busy, res, yes_cnt, in_ready, done} !== '0)
      $display("FAIL t6_reset_mid: busy=%b res=%b yes_cnt=%0d in_ready=%b done=%b want 0",
               busy, res, yes_cnt, in_ready, done);
    else passed++;
    drive_session(2'b00, 1'b0, 1'b0, -1, ROUNDS);
    collect_result(got, lat, y, r, e, single);
    total++;
    if (!got || y != e.yes || y != 256) $display("FAIL t6_yes_cnt: got %0d want %0d", y, e.yes); else passed++;
    total++;
    if (r !== e.res) $display("FAIL t6_res: got %b want %b", r, e.res); else passed++;
  endtask

  initial begin
    test_reset;
    test_t1;
    test_t2;
    test_veto;
    test_unanimous;
    test_bubbles;
    test_reset_mid;
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
